// File: rtl/hdmi_frame_monitor_if.sv
// Pixel stream handshake: RGB 8/8/8 with hsync/vsync/vde timing, valid from the
// source and ready from the sink.
interface hdmi_frame_monitor_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hsync;
    logic       vsync;
    logic       vde;
    logic       valid;
    logic       ready;

    modport master (output r, g, b, hsync, vsync, vde, valid, input ready);
    modport slave  (input r, g, b, hsync, vsync, vde, valid, output ready);
endinterface

// File: rtl/hdmi_frame_monitor.sv
// Pixel stream sink: drives ready (optionally LFSR backpressure), measures frame
// geometry against the configured resolution and sums r+g+b per frame.
module hdmi_frame_monitor #(
    parameter int unsigned XResolution = 1920,
    parameter int unsigned YResolution = 1080,
    parameter int unsigned CntWidth    = 12,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                bp_en_i,
    input  logic                err_clr_i,
    hdmi_frame_monitor_if.slave pix_if,
    output logic                frame_done_o,
    output logic [15:0]         frame_cnt_o,
    output logic [CntWidth-1:0] line_len_o,
    output logic [CntWidth-1:0] line_cnt_o,
    output logic [15:0]         checksum_o,
    output logic                err_line_len_o,
    output logic                err_line_cnt_o,
    output logic                err_proto_o
);

    localparam logic [15:0]         LfsrInit = (LfsrSeed == 16'h0000) ? 16'h0001 : LfsrSeed;
    localparam logic [CntWidth-1:0] CntMax   = '1;
    localparam logic [CntWidth-1:0] XRes     = CntWidth'(XResolution);
    localparam logic [CntWidth-1:0] YRes     = CntWidth'(YResolution);

    typedef enum logic [1:0] {SYNC_WAIT, VSYNC, ACTIVE} state_e;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                ready_q, ready_d;
    logic [CntWidth-1:0] pix_q, pix_d;
    logic [CntWidth-1:0] lines_q, lines_d;
    logic [15:0]         chk_q, chk_d;
    logic                prev_vde_q, prev_vde_d;
    logic [CntWidth-1:0] line_len_q, line_len_d;
    logic [CntWidth-1:0] line_cnt_q, line_cnt_d;
    logic [15:0]         checksum_q, checksum_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                err_len_q, err_len_d;
    logic                err_cnt_q, err_cnt_d;
    logic                err_proto_q, err_proto_d;

    logic                beat;
    logic                vde_eff;
    logic                process_beat;
    logic [9:0]          pix_sum;
    logic                unused_hsync;

    assign unused_hsync = pix_if.hsync;
    assign beat         = pix_if.valid & ready_q;
    // A beat carrying both vsync and vde is a protocol error; its pixel is dropped.
    assign vde_eff      = pix_if.vde & ~pix_if.vsync;
    assign pix_sum      = 10'(pix_if.r) + 10'(pix_if.g) + 10'(pix_if.b);

    // Next-state logic: sync FSM, counters, geometry capture and sticky flags.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ready_d      = bp_en_i ? lfsr_q[0] : 1'b1;
        pix_d        = pix_q;
        lines_d      = lines_q;
        chk_d        = chk_q;
        prev_vde_d   = prev_vde_q;
        line_len_d   = line_len_q;
        line_cnt_d   = line_cnt_q;
        checksum_d   = checksum_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_len_d    = err_len_q & ~err_clr_i;
        err_cnt_d    = err_cnt_q & ~err_clr_i;
        err_proto_d  = err_proto_q & ~err_clr_i;
        process_beat = 1'b0;

        if (beat) begin
            if (pix_if.vsync && pix_if.vde) begin
                err_proto_d = 1'b1;
            end
            case (state_q)
                SYNC_WAIT: if (pix_if.vsync) state_d = VSYNC;
                VSYNC: begin
                    if (!pix_if.vsync) begin
                        state_d      = ACTIVE;
                        process_beat = 1'b1;
                    end
                end
                ACTIVE:  process_beat = 1'b1;
                default: state_d = SYNC_WAIT;
            endcase
        end

        if (process_beat) begin
            if (vde_eff) begin
                if (pix_q != CntMax) pix_d = pix_q + CntWidth'(1);
                chk_d      = chk_q + 16'(pix_sum);
                prev_vde_d = 1'b1;
            end else if (prev_vde_q) begin
                line_len_d = pix_q;
                if (pix_q != XRes) err_len_d = 1'b1;
                if (lines_q != CntMax) lines_d = lines_q + CntWidth'(1);
                pix_d      = '0;
                prev_vde_d = 1'b0;
            end
            // Frame end sees the line count including a line closed on this same beat.
            if (pix_if.vsync) begin
                line_cnt_d   = lines_d;
                checksum_d   = chk_q;
                if (lines_d != YRes) err_cnt_d = 1'b1;
                frame_done_d = 1'b1;
                if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
                lines_d      = '0;
                pix_d        = '0;
                chk_d        = '0;
                state_d      = VSYNC;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= SYNC_WAIT;
            lfsr_q       <= LfsrInit;
            ready_q      <= 1'b0;
            pix_q        <= '0;
            lines_q      <= '0;
            chk_q        <= '0;
            prev_vde_q   <= 1'b0;
            line_len_q   <= '0;
            line_cnt_q   <= '0;
            checksum_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_cnt_q    <= 1'b0;
            err_proto_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            ready_q      <= ready_d;
            pix_q        <= pix_d;
            lines_q      <= lines_d;
            chk_q        <= chk_d;
            prev_vde_q   <= prev_vde_d;
            line_len_q   <= line_len_d;
            line_cnt_q   <= line_cnt_d;
            checksum_q   <= checksum_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            err_len_q    <= err_len_d;
            err_cnt_q    <= err_cnt_d;
            err_proto_q  <= err_proto_d;
        end
    end

    assign pix_if.ready   = ready_q;
    assign frame_done_o   = frame_done_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign line_len_o     = line_len_q;
    assign line_cnt_o     = line_cnt_q;
    assign checksum_o     = checksum_q;
    assign err_line_len_o = err_len_q;
    assign err_line_cnt_o = err_cnt_q;
    assign err_proto_o    = err_proto_q;

endmodule

// File: tb/tb_hdmi_frame_monitor.sv
// Self-checking bench for hdmi_frame_monitor with a 4x3 frame geometry.
module tb_hdmi_frame_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bp_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [11:0] line_len;
    logic [11:0] line_cnt;
    logic [15:0] checksum;
    logic        err_len;
    logic        err_cnt;
    logic        err_proto;

    int ntests = 0;
    int nfail  = 0;
    int fd_pulses = 0;
    int ready_mis = 0;
    bit chk_en = 1'b0;
    bit gaps   = 1'b0;

    hdmi_frame_monitor_if pif ();

    hdmi_frame_monitor #(
        .XResolution(4),
        .YResolution(3),
        .CntWidth   (12),
        .LfsrSeed   (16'hACE1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bp_en_i       (bp_en),
        .err_clr_i     (err_clr),
        .pix_if        (pif),
        .frame_done_o  (frame_done),
        .frame_cnt_o   (frame_cnt),
        .line_len_o    (line_len),
        .line_cnt_o    (line_cnt),
        .checksum_o    (checksum),
        .err_line_len_o(err_len),
        .err_line_cnt_o(err_cnt),
        .err_proto_o   (err_proto)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_pulses <= fd_pulses + 1;
    end

    // Ready reference: LFSR output as a bit sequence x[k] = x[k-16]^x[k-14]^x[k-13]^x[k-11].
    initial begin
        bit          seq[$];
        bit          nb;
        logic        m_ready;
        logic [15:0] seed_v;
        seed_v  = 16'hACE1;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                seq.delete();
                for (int i = 15; i >= 0; i--) seq.push_back(seed_v[i]);
                m_ready = 1'b0;
            end else if (seq.size() == 16) begin
                nb      = seq[0] ^ seq[2] ^ seq[3] ^ seq[5];
                m_ready = bp_en ? seq[15] : 1'b1;
                seq.push_back(nb);
                void'(seq.pop_front());
            end
            #1;
            if (!rst && chk_en && (pif.ready !== m_ready)) ready_mis++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic send_beat(input bit vs, input bit vd, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
        int n;
        bit acc;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            pif.valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        pif.vsync = vs;
        pif.vde   = vd;
        pif.r     = r;
        pif.g     = g;
        pif.b     = b;
        pif.hsync = 1'($urandom_range(0, 1));
        pif.valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc) begin
            acc = pif.ready;
            @(posedge clk);
            @(negedge clk);
            if (!acc) begin
                n++;
                if (n > 200) begin
                    ntests++;
                    nfail++;
                    $display("FAIL beat_timeout: got no accept in %0d cycles, required accept", n);
                    acc = 1'b1;
                end
            end
        end
        pif.valid = 1'b0;
    endtask

    task automatic send_line(input int len, input bit rnd, inout int sum);
        logic [7:0] r, g, b;
        for (int i = 0; i < len; i++) begin
            r = rnd ? 8'($urandom) : 8'd1;
            g = rnd ? 8'($urandom) : 8'd1;
            b = rnd ? 8'($urandom) : 8'd1;
            sum += int'(r) + int'(g) + int'(b);
            send_beat(1'b0, 1'b1, r, g, b);
        end
    endtask

    task automatic send_blank(input int n);
        for (int i = 0; i < n; i++) send_beat(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic send_vsync(input int n);
        for (int i = 0; i < n; i++) send_beat(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int n);
        pif.valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        pif.valid = 1'b0;
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [71:0] all_out;
        rst = 1'b1;
        pif.valid = 1'b0;
        pif.vsync = 1'b0;
        pif.vde = 1'b0;
        pif.hsync = 1'b0;
        pif.r = 8'd0;
        pif.g = 8'd0;
        pif.b = 8'd0;
        repeat (3) @(negedge clk);
        all_out = {pif.ready, frame_done, frame_cnt, line_len, line_cnt, checksum,
                   err_len, err_cnt, err_proto, 3'b000};
        ntests++;
        if (all_out !== 72'd0) begin
            nfail++;
            $display("FAIL reset_state: got %h required 0", all_out);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        ntests++;
        if (pif.ready !== 1'b1) begin
            nfail++;
            $display("FAIL ready_after_reset: got %b required 1", pif.ready);
        end
    endtask

    task automatic run_frames(input int nframes, input bit rnd, input int base_cnt, input string tag);
        int sum, fd0;
        fd0 = fd_pulses;
        send_vsync(2);
        for (int f = 0; f < nframes; f++) begin
            sum = 0;
            for (int l = 0; l < 3; l++) begin
                send_line(4, rnd, sum);
                send_blank(1 + int'($urandom_range(0, 1)));
                ntests++;
                if (line_len !== 12'd4) begin
                    nfail++;
                    $display("FAIL %s line_len: got %0d required 4", tag, line_len);
                end
            end
            send_vsync(1);
            ntests++;
            if (frame_done !== 1'b1 || line_cnt !== 12'd3 || checksum !== 16'(sum)
                || frame_cnt !== 16'(base_cnt + f + 1)) begin
                nfail++;
                $display("FAIL %s frame_end: got done=%b lines=%0d sum=%0d cnt=%0d required done=1 lines=3 sum=%0d cnt=%0d",
                         tag, frame_done, line_cnt, checksum, frame_cnt, 16'(sum), base_cnt + f + 1);
            end
            if (!rnd) begin
                ntests++;
                if (checksum !== 16'd36) begin
                    nfail++;
                    $display("FAIL %s checksum_ones: got %0d required 36", tag, checksum);
                end
            end
            send_vsync(1);
            ntests++;
            if (frame_done !== 1'b0) begin
                nfail++;
                $display("FAIL %s frame_done_pulse: got %b required 0", tag, frame_done);
            end
        end
        ntests++;
        if ((fd_pulses - fd0) !== nframes || {err_len, err_cnt, err_proto} !== 3'b000) begin
            nfail++;
            $display("FAIL %s pulses_errs: got pulses=%0d errs=%b required pulses=%0d errs=000",
                     tag, fd_pulses - fd0, {err_len, err_cnt, err_proto}, nframes);
        end
    endtask

    task automatic test_nominal();
        gaps = 1'b0;
        bp_en = 1'b0;
        run_frames(2, 1'b0, 0, "nominal");
    endtask

    task automatic test_backpressure();
        bp_en = 1'b1;
        gaps = 1'b1;
        idle(40);
        run_frames(2, 1'b0, 2, "bp_ones");
        run_frames(1, 1'b1, 4, "bp_rand");
        ntests++;
        if (ready_mis !== 0) begin
            nfail++;
            $display("FAIL ready_seq: got %0d mismatching cycles required 0", ready_mis);
        end
        bp_en = 1'b0;
        gaps = 1'b0;
        idle(3);
    endtask

    task automatic test_line_len_err();
        int sum;
        sum = 0;
        send_vsync(1);
        send_line(4, 1'b1, sum);
        send_blank(1);
        send_line(5, 1'b1, sum);
        err_clr = 1'b1;
        send_blank(1);
        err_clr = 1'b0;
        ntests++;
        if (err_len !== 1'b1 || line_len !== 12'd5) begin
            nfail++;
            $display("FAIL line_len_err_set: got err=%b len=%0d required err=1 len=5", err_len, line_len);
        end
        pulse_clr();
        ntests++;
        if (err_len !== 1'b0) begin
            nfail++;
            $display("FAIL line_len_err_clr: got %b required 0", err_len);
        end
        send_line(4, 1'b1, sum);
        send_blank(2);
        send_vsync(1);
        ntests++;
        if (line_cnt !== 12'd3 || checksum !== 16'(sum) || err_len !== 1'b0 || err_cnt !== 1'b0
            || frame_cnt !== 16'd6) begin
            nfail++;
            $display("FAIL line_len_frame: got lines=%0d sum=%0d errs=%b%b cnt=%0d required lines=3 sum=%0d errs=00 cnt=6",
                     line_cnt, checksum, err_len, err_cnt, frame_cnt, 16'(sum));
        end
    endtask

    task automatic test_short_frame();
        int sum;
        sum = 0;
        send_vsync(1);
        send_line(4, 1'b1, sum);
        send_blank(2);
        send_line(3, 1'b1, sum);
        send_vsync(1);
        ntests++;
        if (frame_done !== 1'b1 || line_cnt !== 12'd2 || line_len !== 12'd3 || checksum !== 16'(sum)
            || err_cnt !== 1'b1 || err_len !== 1'b1 || frame_cnt !== 16'd7) begin
            nfail++;
            $display("FAIL short_frame: got done=%b lines=%0d len=%0d sum=%0d errs=%b%b cnt=%0d required done=1 lines=2 len=3 sum=%0d errs=11 cnt=7",
                     frame_done, line_cnt, line_len, checksum, err_len, err_cnt, frame_cnt, 16'(sum));
        end
        pulse_clr();
        ntests++;
        if ({err_len, err_cnt} !== 2'b00) begin
            nfail++;
            $display("FAIL short_frame_clr: got %b required 00", {err_len, err_cnt});
        end
    endtask

    task automatic test_proto();
        int sum;
        sum = 0;
        ntests++;
        if (err_proto !== 1'b0) begin
            nfail++;
            $display("FAIL proto_pre: got %b required 0", err_proto);
        end
        send_vsync(1);
        for (int l = 0; l < 3; l++) begin
            send_line(4, 1'b1, sum);
            if (l < 2) send_blank(1);
        end
        send_beat(1'b1, 1'b1, 8'd200, 8'd200, 8'd200);
        ntests++;
        if (err_proto !== 1'b1 || checksum !== 16'(sum) || line_cnt !== 12'd3 || line_len !== 12'd4
            || {err_len, err_cnt} !== 2'b00 || frame_cnt !== 16'd8) begin
            nfail++;
            $display("FAIL proto_beat: got proto=%b sum=%0d lines=%0d len=%0d errs=%b%b cnt=%0d required proto=1 sum=%0d lines=3 len=4 errs=00 cnt=8",
                     err_proto, checksum, line_cnt, line_len, err_len, err_cnt, frame_cnt, 16'(sum));
        end
        pulse_clr();
        ntests++;
        if (err_proto !== 1'b0) begin
            nfail++;
            $display("FAIL proto_clr: got %b required 0", err_proto);
        end
    endtask

    task automatic test_reset_mid();
        int sum, fd0;
        logic [71:0] all_out;
        sum = 0;
        send_vsync(1);
        send_line(2, 1'b1, sum);
        rst = 1'b1;
        @(negedge clk);
        all_out = {pif.ready, frame_done, frame_cnt, line_len, line_cnt, checksum,
                   err_len, err_cnt, err_proto, 3'b000};
        ntests++;
        if (all_out !== 72'd0) begin
            nfail++;
            $display("FAIL reset_mid_state: got %h required 0", all_out);
        end
        rst = 1'b0;
        fd0 = fd_pulses;
        sum = 0;
        for (int l = 0; l < 3; l++) begin
            send_line(4, 1'b1, sum);
            send_blank(1);
        end
        idle(3);
        ntests++;
        if (frame_cnt !== 16'd0 || line_len !== 12'd0 || (fd_pulses - fd0) !== 0) begin
            nfail++;
            $display("FAIL reset_mid_nosync: got cnt=%0d len=%0d pulses=%0d required 0 0 0",
                     frame_cnt, line_len, fd_pulses - fd0);
        end
        sum = 0;
        send_vsync(1);
        for (int l = 0; l < 3; l++) begin
            send_line(4, 1'b1, sum);
            send_blank(1);
        end
        send_vsync(1);
        ntests++;
        if (frame_cnt !== 16'd1 || line_cnt !== 12'd3 || checksum !== 16'(sum)
            || {err_len, err_cnt, err_proto} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_mid_resume: got cnt=%0d lines=%0d sum=%0d required cnt=1 lines=3 sum=%0d",
                     frame_cnt, line_cnt, checksum, 16'(sum));
        end
        idle(2);
        ntests++;
        if (ready_mis !== 0) begin
            nfail++;
            $display("FAIL ready_seq_final: got %0d mismatching cycles required 0", ready_mis);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_line_len_err();
        test_short_frame();
        test_proto();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/hdmi_frame_monitor.md
Name: hdmi_frame_monitor

Overview:
- Stream sink for the pixel valid/ready interface carried by rgb_proc and hdmi_rnd_data_gen: RGB 8/8/8 plus hsync/vsync/vde.
- Sits at the downstream end of a processing chain, where it is the consumer of the handshake.
- Drives ready, optionally applying pseudo-random backpressure.
- Measures frame geometry, checks it against the configured resolution, and accumulates a per-frame pixel checksum.

Parameters:
XResolution  1920  expected active pixels per line
YResolution  1080  expected active lines per frame
CntWidth  12  width of pixel/line counters and reported geometry
LfsrSeed  16'hACE1  backpressure LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
bp_en_i  in  1  1 = ready_o follows the LFSR; 0 = ready_o held high
err_clr_i  in  1  synchronous clear of sticky error flags
r_i, g_i, b_i  in  8 each  pixel colour
hsync_i, vsync_i, vde_i  in  1 each  timing metadata
valid_i  in  1  upstream beat valid
ready_o  out  1  sink ready (registered)
frame_done_o  out  1  one-cycle pulse at end of frame
frame_cnt_o  out  16  completed frames, saturating
line_len_o  out  CntWidth  active pixel count of last completed line
line_cnt_o  out  CntWidth  active line count of last completed frame
checksum_o  out  16  sum of r+g+b over all active pixels of last completed frame, mod 2^16
err_line_len_o  out  1  sticky: a line length differed from XResolution
err_line_cnt_o  out  1  sticky: a frame line count differed from YResolution
err_proto_o  out  1  sticky: a beat had vsync_i=1 and vde_i=1

Behaviour:
- Transfer (beat) = valid_i & ready_o. All state except the LFSR and ready_o advances only on a beat.
- ready_o is registered and never depends combinationally on valid_i:
  - next ready_o = bp_en_i ? lfsr[0] : 1.
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) shifts every cycle.
- Reset values: ready_o=0; LFSR=seed; all counters, outputs and flags 0; FSM in SYNC_WAIT; prev_vde=0.
- FSM state SYNC_WAIT: ignore all beats until a beat with vsync_i=1 -> VSYNC. Nothing is counted; partial frames after reset are discarded.
- FSM state VSYNC: on a beat with vsync_i=0 -> ACTIVE. That beat is processed as an ACTIVE beat in the same cycle.
- FSM state ACTIVE, beat with vde_i=1:
  - pix_cnt++, saturating at all-ones.
  - chk_acc += r+g+b (10-bit sum zero-extended, wrapping at 16 bits).
  - prev_vde <= 1.
- FSM state ACTIVE, beat with vde_i=0 and prev_vde=1 (line end):
  - line_len_o <= pix_cnt.
  - err_line_len_o set if pix_cnt != XResolution.
  - lines++, saturating; pix_cnt <= 0; prev_vde <= 0.
- FSM state ACTIVE, beat with vsync_i=1 (frame end):
  - If prev_vde=1, perform line-end handling first in the same cycle; that line counts.
  - line_cnt_o <= lines; checksum_o <= chk_acc.
  - err_line_cnt_o set if lines != YResolution.
  - frame_done_o=1 for the next cycle; frame_cnt_o++, saturating at 16'hFFFF.
  - Clear lines, pix_cnt and chk_acc -> VSYNC.
- A beat with vsync_i=1 and vde_i=1 sets err_proto_o; vde_i is treated as 0 on that beat.
- hsync_i is not used for geometry; it is only passed through the handshake.
- Latency: geometry outputs and frame_done_o update one cycle after the closing beat.
- Error flags:
  - A flag being set in the same cycle as err_clr_i wins over the clear.
  - Flags clear only via err_clr_i or reset.
- Reset asserted mid-frame: immediate return to reset values; counting resumes only after the next vsync.

Test Plan:
- Reset, bp_en_i=0, XResolution=4, YResolution=3: send 2 frames of 3 lines × 4 pixels, all pixels r=g=b=1 -> frame_done_o pulses twice, frame_cnt_o=2 (the first frame after the first vsync is counted), line_len_o=4, line_cnt_o=3, checksum_o=36, no errors.
- bp_en_i=1 with the same stream and valid_i held high -> ready_o toggles per the LFSR, and results are identical to the previous scenario.
- One line of 5 pixels in a frame -> err_line_len_o=1 and line_len_o=5 after that line; err_clr_i clears the flag.
- Frame with 2 lines, ending on a vsync beat directly after vde=1 -> line closed and counted, line_cnt_o=2, err_line_cnt_o=1.
- Beat with vsync=vde=1 -> err_proto_o=1; the pixel is not counted or summed.
- Assert rst_i mid-line -> all outputs 0 next cycle; stream restarted without a vsync -> no counting until vsync.
